// File: rtl/sync_frame_pkg.sv
// sync_frame_pkg
// Shared definitions for the sync-triggered frame capture block:
//   state_t        - capture FSM states
//   DATA_W_DEF     - default payload width
//   PARITY_ODD_DEF - default parity sense (0 = even)
package sync_frame_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam bit PARITY_ODD_DEF = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/sync_frame_capture_frame_out_reg.sv
// frame_out_reg
// One-entry valid/ready holding register for captured frames.
// Ports:
//   clk, areset  - clock, asynchronous active-high reset
//   load         - a good frame is offered this cycle
//   data_in      - the offered frame
//   out_ready    - consumer accepts out_data this cycle
//   out_data     - held frame, stable until accepted
//   out_valid    - out_data holds an unaccepted frame
//   overrun      - one-cycle pulse: offered frame dropped because the
//                  register was full and not being drained
module frame_out_reg
  import sync_frame_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic              overrun_reg;
  logic              accept;

  assign accept = valid_reg && out_ready;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= load && valid_reg && !out_ready;
      // A load is allowed when empty or when the held word leaves on
      // this same edge, so a full register can be refilled with no bubble.
      if (load && (!valid_reg || out_ready)) begin
        data_reg  <= data_in;
        valid_reg <= 1'b1;
      end else if (accept) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/sync_frame_capture.sv
// sync_frame_capture
// Captures a DATA_W-bit LSB-first payload, a parity bit and a stop bit
// after each sync pulse from the upstream "101" detector, and presents
// good frames through a one-entry valid/ready output register.
// Ports:
//   clk, areset  - clock, asynchronous active-high reset
//   in           - serial bit stream (one bit per cycle)
//   sync         - high in the cycle whose `in` is payload bit 0
//   out_ready    - consumer accepts out_data
//   out_data     - captured payload, bit 0 = first bit received
//   out_valid    - out_data holds an unaccepted frame
//   busy         - frame capture in progress
//   frame_err    - one-cycle pulse: stop bit was 0
//   parity_err   - one-cycle pulse: parity mismatch with good stop bit
//   overrun      - one-cycle pulse: good frame dropped, output full
module sync_frame_capture
  import sync_frame_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = PARITY_ODD_DEF
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in,
  input  logic              sync,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  // Counter value while the final payload bit is being sampled: the
  // counter holds the index of the bit received on the previous cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 2);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              par_reg;
  logic              frame_err_reg;
  logic              parity_err_reg;

  logic              shift_en;
  logic              stop_cycle;
  logic              load;

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; sync only matters in IDLE, there is no mid-frame
  // resynchronisation.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sync) state_next = DATA;
      DATA:    if (cnt_reg == LAST_CNT) state_next = PARITY;
      PARITY:  state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy       = (state_reg != IDLE);
    shift_en   = ((state_reg == IDLE) && sync) || (state_reg == DATA);
    stop_cycle = (state_reg == STOP);
    // par_reg already folds in the parity bit, so it must equal the
    // configured parity sense; stop bit is the live input.
    load       = stop_cycle && in && (par_reg == PARITY_ODD);
  end

  // Shift register, bit counter, parity accumulator and error pulses
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_reg        <= '0;
      shift_reg      <= '0;
      par_reg        <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      // Right shift with the new bit at the MSB: after DATA_W shifts the
      // first bit received ends up in bit 0.
      if (shift_en) begin
        shift_reg <= {in, shift_reg[DATA_W-1:1]};
      end
      if (state_reg == IDLE) begin
        cnt_reg <= '0;
        par_reg <= in;
      end else if (state_reg == DATA) begin
        cnt_reg <= cnt_reg + 1'b1;
        par_reg <= par_reg ^ in;
      end else if (state_reg == PARITY) begin
        par_reg <= par_reg ^ in;
      end
      frame_err_reg  <= stop_cycle && !in;
      parity_err_reg <= stop_cycle && in && (par_reg != PARITY_ODD);
    end
  end

  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;

  frame_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .areset    (areset),
    .load      (load),
    .data_in   (shift_reg),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_sync_frame_capture.sv
// tb_sync_frame_capture
// Directed and randomized frames against a frame-level reference model
// built from the recorded bit history of the serial stream.
module tb_sync_frame_capture;

  localparam int W       = 8;
  localparam bit PAR_ODD = 1'b0;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         in = 1'b0;
  logic         sync = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         busy;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_frame_capture #(
    .DATA_W     (W),
    .PARITY_ODD (PAR_ODD)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .in         (in),
    .sync       (sync),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // Reference model state: bit history, frame start cycle, output word
  bit           hist [0:8191];
  int           cyc = 0;
  bit           active = 1'b0;
  int           start = 0;
  bit           e_valid = 1'b0;
  logic [W-1:0] e_data = '0;
  bit           e_busy = 1'b0;
  bit           e_ferr = 1'b0;
  bit           e_perr = 1'b0;
  bit           e_ovr = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input bit b, input bit s, input bit r);
    bit           idle_now;
    bit           good;
    logic [W-1:0] pl;
    int           ones;
    idle_now = !active;
    good     = 1'b0;
    pl       = '0;
    hist[cyc] = b;
    e_ferr = 1'b0;
    e_perr = 1'b0;
    e_ovr  = 1'b0;
    if (active && cyc == start + W + 1) begin
      for (int i = 0; i < W; i++) pl[i] = hist[start + i];
      ones = $countones(pl) + int'(hist[start + W]);
      if (!b) e_ferr = 1'b1;
      else if ((ones % 2) != int'(PAR_ODD)) e_perr = 1'b1;
      else good = 1'b1;
      active = 1'b0;
    end
    if (idle_now && s) begin
      active = 1'b1;
      start  = cyc;
    end
    if (good) begin
      if (!e_valid || r) begin
        e_data  = pl;
        e_valid = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (e_valid && r) begin
      e_valid = 1'b0;
    end
    e_busy = active;
    cyc++;
  endtask

  task automatic model_reset();
    active  = 1'b0;
    e_valid = 1'b0;
    e_data  = '0;
    e_busy  = 1'b0;
    e_ferr  = 1'b0;
    e_perr  = 1'b0;
    e_ovr   = 1'b0;
  endtask

  task automatic check_all();
    chk1("out_valid", out_valid, e_valid);
    chk8("out_data", out_data, e_data);
    chk1("busy", busy, e_busy);
    chk1("frame_err", frame_err, e_ferr);
    chk1("parity_err", parity_err, e_perr);
    chk1("overrun", overrun, e_ovr);
  endtask

  task automatic tick(input bit b, input bit s, input bit r);
    @(negedge clk);
    in        = b;
    sync      = s;
    out_ready = r;
    @(posedge clk);
    model_edge(b, s, r);
    #1;
    check_all();
  endtask

  // rmode: 0 = ready low, 1 = ready high, 2 = random; stop_rdy overrides
  // ready in the stop cycle for rmode 0/1. noise adds ignored sync pulses.
  task automatic send_frame(input logic [W-1:0] p, input bit pb, input bit st,
                            input int rmode, input bit stop_rdy, input bit noise);
    bit b;
    bit s;
    bit r;
    for (int i = 0; i < W + 2; i++) begin
      if (i < W) b = p[i];
      else if (i == W) b = pb;
      else b = st;
      s = (i == 0) || (noise && (i == 3 || $urandom_range(0, 2) == 0));
      if (rmode == 2) r = 1'($urandom_range(0, 1));
      else if (i == W + 1) r = stop_rdy;
      else r = (rmode == 1);
      tick(b, s, r);
    end
    $display("frame payload=%02h parity=%0d stop=%0d valid=%0d data=%02h ferr=%0d perr=%0d ovr=%0d",
             p, pb, st, out_valid, out_data, frame_err, parity_err, overrun);
  endtask

  initial begin
    logic [W-1:0] p;
    bit           pb;
    bit           st;

    // Reset state
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_valid", out_valid, 1'b0);
    chk8("rst_data", out_data, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ferr", frame_err, 1'b0);
    chk1("rst_perr", parity_err, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);

    // Good frame 0xA5, visible in k+10 only
    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    chk1("a5_valid", out_valid, 1'b1);
    chk8("a5_data", out_data, 8'hA5);
    tick(1'b0, 1'b0, 1'b1);
    chk1("a5_valid_drop", out_valid, 1'b0);

    // Parity error
    send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    chk1("3c_perr", parity_err, 1'b1);
    chk1("3c_valid", out_valid, 1'b0);
    tick(1'b0, 1'b0, 1'b1);

    // Frame error dominates a bad parity bit
    send_frame(8'hFF, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    chk1("ff_ferr", frame_err, 1'b1);
    chk1("ff_perr", parity_err, 1'b0);
    chk1("ff_valid", out_valid, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    // Backpressure: back-to-back 0x12, 0x34 with ready low
    send_frame(8'h12, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    chk1("bp_ovr", overrun, 1'b1);
    chk8("bp_data", out_data, 8'h12);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk1("bp_drained", out_valid, 1'b0);
    tick(1'b0, 1'b0, 1'b0);

    // Simultaneous accept and load
    send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    chk8("sim_data", out_data, 8'hAA);
    chk1("sim_valid", out_valid, 1'b1);
    chk1("sim_ovr", overrun, 1'b0);
    tick(1'b0, 1'b0, 1'b1);

    // Ignored sync pulses inside the frame
    send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    chk8("noise_data", out_data, 8'h5A);
    chk1("noise_valid", out_valid, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Reset at k+4 with a held word and a partial frame
    send_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    p = 8'h0F;
    for (int i = 0; i < 4; i++) tick(p[i], i == 0, 1'b0);
    @(negedge clk);
    areset = 1'b1;
    sync   = 1'b0;
    in     = 1'b0;
    #1;
    model_reset();
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_valid", out_valid, 1'b0);
    chk8("arst_data", out_data, 8'h00);
    @(negedge clk);
    areset = 1'b0;
    send_frame(8'h96, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    chk8("post_rst_data", out_data, 8'h96);
    chk1("post_rst_valid", out_valid, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Randomized frames with random gaps, noise and backpressure
    for (int n = 0; n < 40; n++) begin
      p  = W'($urandom);
      pb = (^p) ^ PAR_ODD ^ ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      send_frame(p, pb, st, 2, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) tick(1'($urandom), 1'b0, 1'($urandom));
    end
    repeat (3) tick(1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
